// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : mem_arb_pkg                                                     |
// | Purpose : owner encoding and shared widths for the RAM arbiter slice      |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2,
        OWN_HOST  = 2'd3
    } owner_t;

    localparam int DEF_AW       = 8;
    localparam int DEF_DW       = 8;
    localparam int STARVE_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arb_tagpipe.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : mem_arb_tagpipe                                                 |
// | Purpose : owner-tag shift register; last stage decodes per-port rvalid    |
// | Rev     : 1.0   (host output present with MEM_ARBITER_HOST_EN)            |
// +---------------------------------------------------------------------------+
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output logic   f_rvalid,
    output logic   d_rvalid,
`ifdef MEM_ARBITER_HOST_EN
    output logic   h_rvalid,
`endif
    output logic   busy
);

    owner_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= OWN_NONE;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign f_rvalid = (pipe[DEPTH-1] == OWN_FETCH);
    assign d_rvalid = (pipe[DEPTH-1] == OWN_DATA);
`ifdef MEM_ARBITER_HOST_EN
    assign h_rvalid = (pipe[DEPTH-1] == OWN_HOST);
`endif

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy = busy | (pipe[i] != OWN_NONE);
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : mem_arbiter                                                     |
// | Purpose : host > data > fetch RAM arbiter with fetch anti-starvation;     |
// |           optional host port enabled by MEM_ARBITER_HOST_EN               |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
`ifdef MEM_ARBITER_HOST_EN
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    logic                    host_req;
    logic                    host_we;
    logic [AW-1:0]           host_addr;
    logic [DW-1:0]           host_wdata;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    starved;
    owner_t                  win;
    owner_t                  tag_in;
    logic                    sel_we;
    logic [AW-1:0]           sel_addr;
    logic [DW-1:0]           sel_wdata;
    logic                    pipe_busy;

`ifdef MEM_ARBITER_HOST_EN
    assign host_req   = h_req;
    assign host_we    = h_we;
    assign host_addr  = h_addr;
    assign host_wdata = h_wdata;
`else
    assign host_req   = 1'b0;
    assign host_we    = 1'b0;
    assign host_addr  = '0;
    assign host_wdata = '0;
`endif

    assign starved = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        win = OWN_NONE;
        if (host_req)                         win = OWN_HOST;
        else if (f_req && (starved || !d_req)) win = OWN_FETCH;
        else if (d_req)                       win = OWN_DATA;
        if (!rst) win = OWN_NONE;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            OWN_FETCH: sel_addr = f_addr;
            OWN_DATA: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            OWN_HOST: begin
                sel_we    = host_we;
                sel_addr  = host_addr;
                sel_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    assign f_gnt  = (win == OWN_FETCH);
    assign d_gnt  = (win == OWN_DATA);
    assign tag_in = (win != OWN_NONE && !sel_we) ? win : OWN_NONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_rden   <= 1'b0;
            ram_wren   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            ram_rden <= 1'b0;
            ram_wren <= 1'b0;
            if (win != OWN_NONE) begin
                ram_addr <= sel_addr;
                ram_data <= sel_wdata;
                ram_rden <= !sel_we;
                ram_wren <= sel_we;
            end
            // Saturating at the threshold keeps fetch promoted until it is served.
            if (f_req && !f_gnt) begin
                if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    mem_arb_tagpipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tagpipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .f_rvalid (f_rvalid),
        .d_rvalid (d_rvalid),
`ifdef MEM_ARBITER_HOST_EN
        .h_rvalid (h_rvalid),
`endif
        .busy     (pipe_busy)
    );

    assign f_rdata = ram_q;
    assign d_rdata = ram_q;
`ifdef MEM_ARBITER_HOST_EN
    assign h_gnt   = (win == OWN_HOST);
    assign h_rdata = ram_q;
`endif

    assign busy = ram_rden | ram_wren | pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                                  |
// | Purpose : RD_LAT=1 and RD_LAT=2 arbiters on shared stimulus vs. a model   |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef MEM_ARBITER_HOST_EN
    localparam bit HOST = 1'b1;
`else
    localparam bit HOST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       f_req, d_req, d_we, h_req, h_we;
    logic [7:0] f_addr, d_addr, d_wdata, h_addr, h_wdata;

    logic       f_gnt [2], f_rvalid [2], d_gnt [2], d_rvalid [2];
    logic       h_gnt [2], h_rvalid [2];
    logic       ram_rden [2], ram_wren [2], busy [2];
    logic [7:0] f_rdata [2], d_rdata [2], h_rdata [2];
    logic [7:0] ram_addr [2], ram_data [2], ram_q [2];

    function automatic logic [7:0] init_val(int i);
        return 8'((i * 37 + 11) ^ 8'h5A);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [7:0] mem [256];
        logic [7:0] q1, q2;

        // Behavioural RAM: contents restored while reset is held.
        always @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            end else if (ram_wren[k]) begin
                mem[ram_addr[k]] <= ram_data[k];
            end
            if (ram_rden[k]) q1 <= mem[ram_addr[k]];
            q2 <= q1;
        end
        assign ram_q[k] = (k == 0) ? q1 : q2;

        mem_arbiter #(
            .AW(8), .DW(8), .RD_LAT(k + 1), .STARVE_MAX(STARVE_MAX)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .f_req    (f_req),
            .f_addr   (f_addr),
            .f_gnt    (f_gnt[k]),
            .f_rvalid (f_rvalid[k]),
            .f_rdata  (f_rdata[k]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt[k]),
            .d_rvalid (d_rvalid[k]),
            .d_rdata  (d_rdata[k]),
`ifdef MEM_ARBITER_HOST_EN
            .h_req    (h_req),
            .h_we     (h_we),
            .h_addr   (h_addr),
            .h_wdata  (h_wdata),
            .h_gnt    (h_gnt[k]),
            .h_rvalid (h_rvalid[k]),
            .h_rdata  (h_rdata[k]),
`endif
            .ram_addr (ram_addr[k]),
            .ram_data (ram_data[k]),
            .ram_rden (ram_rden[k]),
            .ram_wren (ram_wren[k]),
            .ram_q    (ram_q[k]),
            .busy     (busy[k])
        );
    end

`ifndef MEM_ARBITER_HOST_EN
    initial begin
        for (int k = 0; k < 2; k++) begin
            h_gnt[k] = 1'b0; h_rvalid[k] = 1'b0; h_rdata[k] = 8'h00;
        end
    end
`endif

    // Reference model: priority rule, starvation count, memory image, read log.
    typedef struct { int g; int own; logic [7:0] data; } rd_t;
    rd_t        rdq [$];
    int         hd [2];
    int         cyc = 0, starve = 0, last_own = 0;
    int         n_tests = 0, n_fail = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] last_f_rdata [2], last_d_rdata [2], last_h_rdata [2];

    task automatic model_reset();
        starve = 0;
        hd[0]  = rdq.size();
        hd[1]  = rdq.size();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int         own;
        logic       we;
        logic [7:0] a, wd;
        logic       ef, ed, eh;
        logic [7:0] edat;
        #1;
        own = 0;
        if (rst) begin
            if (HOST && h_req)                              own = 3;
            else if (f_req && (starve == STARVE_MAX || !d_req)) own = 1;
            else if (d_req)                                 own = 2;
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({f_gnt[k], d_gnt[k], h_gnt[k]} !== {own == 1, own == 2, own == 3}) begin
                n_fail++;
                $display("FAIL gnt[%0d] cyc %0d got f/d/h=%b%b%b exp owner %0d",
                         k, cyc, f_gnt[k], d_gnt[k], h_gnt[k], own);
            end
        end
        last_own = own;
        we = 1'b0; a = 8'h00; wd = 8'h00;
        case (own)
            1: a = f_addr;
            2: begin we = d_we; a = d_addr; wd = d_wdata; end
            3: begin we = h_we; a = h_addr; wd = h_wdata; end
            default: ;
        endcase
        if (own != 0) begin
            if (we) ref_mem[a] = wd;
            else    rdq.push_back('{cyc, own, ref_mem[a]});
        end
        if (f_req && own != 1) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else                   starve = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            ef = 1'b0; ed = 1'b0; eh = 1'b0; edat = 8'h00;
            if (hd[k] < rdq.size() && rdq[hd[k]].g + 2 + k == cyc) begin
                ef   = (rdq[hd[k]].own == 1);
                ed   = (rdq[hd[k]].own == 2);
                eh   = (rdq[hd[k]].own == 3);
                edat = rdq[hd[k]].data;
                hd[k]++;
            end
            n_tests++;
            if ({f_rvalid[k], d_rvalid[k], h_rvalid[k]} !== {ef, ed, eh}) begin
                n_fail++;
                $display("FAIL rvalid[%0d] cyc %0d got f/d/h=%b%b%b exp %b%b%b",
                         k, cyc, f_rvalid[k], d_rvalid[k], h_rvalid[k], ef, ed, eh);
            end
            if (ef || ed || eh) begin
                n_tests++;
                if (ram_q[k] !== edat) begin
                    n_fail++;
                    $display("FAIL rdata[%0d] cyc %0d got %h exp %h", k, cyc, ram_q[k], edat);
                end
                if (ef) last_f_rdata[k] = f_rdata[k];
                if (ed) last_d_rdata[k] = d_rdata[k];
                if (eh) last_h_rdata[k] = h_rdata[k];
            end
        end
    endtask

    task automatic idle(int n);
        f_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; h_req = 1'b0; h_we = 1'b0;
        f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00; h_addr = 8'h00; h_wdata = 8'h00;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({ram_rden[k], ram_wren[k], busy[k], f_gnt[k], d_gnt[k], f_rvalid[k], d_rvalid[k]} !== 7'b0
                || ram_addr[k] !== 8'h00 || ram_data[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got ctl=%b%b%b gnt=%b%b addr=%h data=%h exp all 0",
                         k, ram_rden[k], ram_wren[k], busy[k], f_gnt[k], d_gnt[k], ram_addr[k], ram_data[k]);
            end
        end
        rst = 1'b1;
        model_reset();
        d_req = 1'b1; f_req = 1'b0; d_addr = 8'($urandom); step();
        d_req = 1'b0; f_req = 1'b1; f_addr = 8'($urandom); step();
        f_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({ram_rden[k], ram_wren[k], busy[k], f_rvalid[k], d_rvalid[k]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_inflight[%0d] got rden/wren/busy/frv/drv=%b%b%b%b%b exp 00000",
                         k, ram_rden[k], ram_wren[k], busy[k], f_rvalid[k], d_rvalid[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(4);
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 4; i++) begin
            f_req = 1'b1; f_addr = 8'(i); d_req = 1'b0;
            step();
            n_tests++;
            if (last_own !== 1) begin
                n_fail++;
                $display("FAIL fetch_stream_gnt i=%0d got owner %0d exp 1", i, last_own);
            end
        end
        idle(4);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (last_f_rdata[k] !== init_val(3)) begin
                n_fail++;
                $display("FAIL fetch_stream_last[%0d] got %h exp %h", k, last_f_rdata[k], init_val(3));
            end
        end
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'hA5; step();
        d_we = 1'b0; step();
        idle(4);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (last_d_rdata[k] !== 8'hA5) begin
                n_fail++;
                $display("FAIL write_read[%0d] got %h exp a5", k, last_d_rdata[k]);
            end
        end
    endtask

    task automatic test_conflict();
        f_addr = 8'($urandom);
        for (int i = 0; i < 15; i++) begin
            f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'($urandom);
            step();
            n_tests++;
            if (last_own !== ((i % 5 == 4) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL conflict_pattern i=%0d got owner %0d exp %0d", i, last_own, (i % 5 == 4) ? 1 : 2);
            end
            if (last_own == 1) f_addr = 8'($urandom);
        end
        idle(4);
    endtask

    task automatic test_mixed();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; f_req = 1'b0; step();
        d_req = 1'b0; f_req = 1'b1; f_addr = 8'h20; step();
        d_req = 1'b1; d_addr = 8'h11; f_req = 1'b0; step();
        d_req = 1'b0; f_req = 1'b1; f_addr = 8'h21; step();
        idle(4);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (last_d_rdata[k] !== init_val(8'h11) || last_f_rdata[k] !== init_val(8'h21)) begin
                n_fail++;
                $display("FAIL mixed_last[%0d] got d=%h f=%h exp d=%h f=%h", k,
                         last_d_rdata[k], last_f_rdata[k], init_val(8'h11), init_val(8'h21));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (!f_req || last_own == 1) begin
                f_req = 1'($urandom_range(0, 1)); f_addr = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                f_req = 1'b0;
            end
            if (!d_req || last_own == 2) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = 8'($urandom_range(0, 15)); d_wdata = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                d_req = 1'b0;
            end
            step();
        end
        idle(4);
    endtask

`ifdef MEM_ARBITER_HOST_EN
    task automatic test_host();
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h00; h_wdata = 8'h7F;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33; f_req = 1'b1; f_addr = 8'h00;
        step();
        n_tests++;
        if (last_own !== 3) begin
            n_fail++;
            $display("FAIL host_priority got owner %0d exp 3", last_own);
        end
        h_req = 1'b0; d_req = 1'b0; step();
        idle(4);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (last_f_rdata[k] !== 8'h7F) begin
                n_fail++;
                $display("FAIL host_write_fetch[%0d] got %h exp 7f", k, last_f_rdata[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_stream();
        test_write_read();
        test_conflict();
        test_mixed();
        test_random();
`ifdef MEM_ARBITER_HOST_EN
        test_host();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
